// File: rtl/archer_projectile_scheduler_if.sv
// Handshake bundle between the archer projectile scheduler, the shared
// projectile-update datapath, the sprite renderer and the boss damage logic.
interface archer_projectile_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = 2
);
    logic                 frame_tick;
    logic [1:0]           game_active;
    logic                 fire_req;
    logic                 launch_valid;
    logic [SLOT_W-1:0]    launch_slot;
    logic                 upd_start;
    logic [SLOT_W-1:0]    upd_slot;
    logic                 upd_done;
    logic                 upd_hit;
    logic                 upd_offscreen;
    logic [NUM_SLOTS-1:0] slot_active;
    logic                 attack_hit;
    logic                 busy;
    logic                 overrun;

    // The game side drives frame/fire/datapath results and observes the scheduler.
    modport master (
        output frame_tick, game_active, fire_req, upd_done, upd_hit, upd_offscreen,
        input  launch_valid, launch_slot, upd_start, upd_slot, slot_active,
               attack_hit, busy, overrun
    );

    modport slave (
        input  frame_tick, game_active, fire_req, upd_done, upd_hit, upd_offscreen,
        output launch_valid, launch_slot, upd_start, upd_slot, slot_active,
               attack_hit, busy, overrun
    );
endinterface

// File: rtl/archer_projectile_scheduler.sv
// Archer multi-shot controller: allocates projectile slots on fire, then on each
// frame sweeps one shared update datapath over the live slots and retires them.
module archer_projectile_scheduler #(
    parameter int NUM_SLOTS           = 4,
    parameter int SLOT_W              = 2,
    parameter int PROJECTILE_LIFETIME = 60,
    parameter int FIRE_COOLDOWN       = 6
) (
    input logic                          clk,
    input logic                          rst,
    archer_projectile_scheduler_if.slave bus
);
    localparam int LIFE_W = $clog2(PROJECTILE_LIFETIME + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_e;

    state_e               state_q, state_d;
    logic [NUM_SLOTS-1:0] sweep_mask_q, sweep_mask_d;
    logic [SLOT_W-1:0]    cur_slot_q, cur_slot_d;
    logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
    logic [LIFE_W-1:0]    lifetime_q [NUM_SLOTS];
    logic [LIFE_W-1:0]    lifetime_d [NUM_SLOTS];
    logic [7:0]           cooldown_q, cooldown_d;
    logic                 launch_valid_q, launch_valid_d;
    logic [SLOT_W-1:0]    launch_slot_q, launch_slot_d;
    logic                 attack_hit_q, attack_hit_d;
    logic                 overrun_q, overrun_d;

    logic                 active;
    logic                 busy;
    logic                 accept;
    logic [SLOT_W-1:0]    alloc_slot;
    logic [NUM_SLOTS-1:0] remaining;

    function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_SLOTS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = SLOT_W'(i);
        end
    endfunction

    assign active     = (bus.game_active == 2'd1);
    assign busy       = (state_q != IDLE);
    // Free-slot choice uses the registered mask, so a slot retired this cycle
    // only becomes allocatable on the following cycle.
    assign alloc_slot = lowest_set(~slot_active_q);
    assign accept     = bus.fire_req && active && (cooldown_q == 8'd0) && !(&slot_active_q);
    assign remaining  = sweep_mask_q & ~(NUM_SLOTS'(1) << cur_slot_q);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement can leave it unassigned and infer a latch.
        state_d        = state_q;
        sweep_mask_d   = sweep_mask_q;
        cur_slot_d     = cur_slot_q;
        slot_active_d  = slot_active_q;
        lifetime_d     = lifetime_q;
        cooldown_d     = cooldown_q;
        launch_valid_d = 1'b0;
        launch_slot_d  = launch_slot_q;
        attack_hit_d   = 1'b0;
        overrun_d      = overrun_q | (bus.frame_tick && busy);

        if (bus.frame_tick && cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;

        case (state_q)
            IDLE: begin
                if (bus.frame_tick && active) begin
                    sweep_mask_d = slot_active_q;
                    if (|slot_active_q) begin
                        state_d    = ISSUE;
                        cur_slot_d = lowest_set(slot_active_q);
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.upd_done) begin
                    state_d = NEXT;
                    if (bus.upd_hit) begin
                        slot_active_d[cur_slot_q] = 1'b0;
                        attack_hit_d              = 1'b1;
                    end else if (bus.upd_offscreen) begin
                        slot_active_d[cur_slot_q] = 1'b0;
                    end else begin
                        if (lifetime_q[cur_slot_q] != '0)
                            lifetime_d[cur_slot_q] = lifetime_q[cur_slot_q] - LIFE_W'(1);
                        if (lifetime_q[cur_slot_q] <= LIFE_W'(1))
                            slot_active_d[cur_slot_q] = 1'b0;
                    end
                end
            end
            NEXT: begin
                sweep_mask_d = remaining;
                cur_slot_d   = lowest_set(remaining);
                state_d      = (|remaining) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The allocated slot is free, so it never collides with the slot being retired.
        if (accept) begin
            slot_active_d[alloc_slot] = 1'b1;
            lifetime_d[alloc_slot]    = LIFE_W'(PROJECTILE_LIFETIME);
            cooldown_d                = 8'(FIRE_COOLDOWN);
            launch_valid_d            = 1'b1;
            launch_slot_d             = alloc_slot;
        end

        // Leaving gameplay abandons any sweep in flight; late datapath results are dropped.
        if (!active) begin
            state_d       = IDLE;
            sweep_mask_d  = '0;
            slot_active_d = '0;
            cooldown_d    = 8'd0;
            attack_hit_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sweep_mask_q   <= '0;
            cur_slot_q     <= '0;
            slot_active_q  <= '0;
            cooldown_q     <= 8'd0;
            launch_valid_q <= 1'b0;
            launch_slot_q  <= '0;
            attack_hit_q   <= 1'b0;
            overrun_q      <= 1'b0;
            // NOTE: the lifetime array is small and its reset value is observable
            // behaviour, so it is cleared here rather than left as a bare memory.
            for (int i = 0; i < NUM_SLOTS; i++) lifetime_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            sweep_mask_q   <= sweep_mask_d;
            cur_slot_q     <= cur_slot_d;
            slot_active_q  <= slot_active_d;
            cooldown_q     <= cooldown_d;
            launch_valid_q <= launch_valid_d;
            launch_slot_q  <= launch_slot_d;
            attack_hit_q   <= attack_hit_d;
            overrun_q      <= overrun_d;
            lifetime_q     <= lifetime_d;
        end
    end

    assign bus.launch_valid = launch_valid_q;
    assign bus.launch_slot  = launch_slot_q;
    assign bus.upd_start    = (state_q == ISSUE);
    assign bus.upd_slot     = cur_slot_q;
    assign bus.slot_active  = slot_active_q;
    assign bus.attack_hit   = attack_hit_q;
    assign bus.busy         = busy;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_archer_projectile_scheduler.sv
// Directed bench for archer_projectile_scheduler: the bench plays the update
// datapath and checks launches, sweeps, retirement, overrun and game exit.
module tb_archer_projectile_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    archer_projectile_scheduler_if #(.NUM_SLOTS(4), .SLOT_W(2)) bus ();

    archer_projectile_scheduler #(
        .NUM_SLOTS(4), .SLOT_W(2), .PROJECTILE_LIFETIME(60), .FIRE_COOLDOWN(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 ns after the rising edge, outputs are sampled there too.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic fire();
        bus.fire_req = 1'b1;
        step();
        bus.fire_req = 1'b0;
    endtask

    task automatic reset_dut();
        rst               = 1'b1;
        bus.frame_tick    = 1'b0;
        bus.game_active   = 2'd0;
        bus.fire_req      = 1'b0;
        bus.upd_done      = 1'b0;
        bus.upd_hit       = 1'b0;
        bus.upd_offscreen = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Acts as the update datapath for one slot: waits for upd_start, answers after delay.
    task automatic serve(input int slot, input logic hit, input logic off, input int delay);
        int k = 0;
        while (bus.upd_start !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("upd_start", 32'(bus.upd_start), 32'd1);
        check("upd_slot", 32'(bus.upd_slot), 32'(slot));
        step(1 + delay);
        check("upd_start_pulse", 32'(bus.upd_start), 32'd0);
        check("upd_slot_hold", 32'(bus.upd_slot), 32'(slot));
        bus.upd_done      = 1'b1;
        bus.upd_hit       = hit;
        bus.upd_offscreen = off;
        step();
        bus.upd_done      = 1'b0;
        bus.upd_hit       = 1'b0;
        bus.upd_offscreen = 1'b0;
        check("attack_hit", 32'(bus.attack_hit), 32'(hit));
    endtask

    task automatic sweep(input logic [3:0] mask, input logic [3:0] hits);
        frame();
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) serve(i, hits[i], 1'b0, 0);
        end
        step();
        check("sweep_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        // Reset values
        reset_dut();
        check("rst_slot_active", 32'(bus.slot_active), 32'd0);
        check("rst_launch_valid", 32'(bus.launch_valid), 32'd0);
        check("rst_upd_start", 32'(bus.upd_start), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_attack_hit", 32'(bus.attack_hit), 32'd0);

        // First shot lands in slot 0, then cooldown gates the next shots
        bus.game_active = 2'd1;
        step();
        fire();
        check("fire1_launch_valid", 32'(bus.launch_valid), 32'd1);
        check("fire1_launch_slot", 32'(bus.launch_slot), 32'd0);
        check("fire1_slot_active", 32'(bus.slot_active), 32'h1);
        step();
        check("fire1_pulse_width", 32'(bus.launch_valid), 32'd0);
        for (int f = 0; f < 3; f++) sweep(4'b0001, 4'b0000);
        fire();
        check("cooldown_reject_lv", 32'(bus.launch_valid), 32'd0);
        check("cooldown_reject_mask", 32'(bus.slot_active), 32'h1);
        step();
        for (int f = 0; f < 3; f++) sweep(4'b0001, 4'b0000);
        fire();
        check("fire2_launch_valid", 32'(bus.launch_valid), 32'd1);
        check("fire2_launch_slot", 32'(bus.launch_slot), 32'd1);
        check("fire2_slot_active", 32'(bus.slot_active), 32'h3);
        step();

        // Slot 0 has had 6 updates; it retires on its 60th plain update
        for (int f = 0; f < 53; f++) sweep(4'b0011, 4'b0000);
        check("life_59_alive", 32'(bus.slot_active), 32'h3);
        sweep(4'b0011, 4'b0000);
        check("life_60_retired", 32'(bus.slot_active), 32'h2);

        // Three live slots, hit with offscreen on slot 1
        reset_dut();
        check("rst2_slot_active", 32'(bus.slot_active), 32'd0);
        bus.game_active = 2'd1;
        step();
        fire();
        check("fill_slot0", 32'(bus.launch_slot), 32'd0);
        for (int f = 0; f < 6; f++) sweep(4'b0001, 4'b0000);
        fire();
        check("fill_slot1", 32'(bus.launch_slot), 32'd1);
        for (int f = 0; f < 6; f++) sweep(4'b0011, 4'b0000);
        fire();
        check("fill_slot2", 32'(bus.launch_slot), 32'd2);
        check("fill_mask3", 32'(bus.slot_active), 32'h7);
        step();
        frame();
        check("sweep_busy_start", 32'(bus.busy), 32'd1);
        serve(0, 1'b0, 1'b0, 0);
        check("sweep_busy_mid", 32'(bus.busy), 32'd1);
        serve(1, 1'b1, 1'b1, 2);
        check("hit_mask", 32'(bus.slot_active), 32'h5);
        step();
        check("hit_single_pulse", 32'(bus.attack_hit), 32'd0);
        check("sweep_busy_late", 32'(bus.busy), 32'd1);
        serve(2, 1'b0, 1'b0, 0);
        step();
        check("sweep_done_busy", 32'(bus.busy), 32'd0);

        // Fill every slot, then a fire_req with zero cooldown must be dropped
        for (int f = 0; f < 5; f++) sweep(4'b0101, 4'b0000);
        fire();
        check("refill_slot1", 32'(bus.launch_slot), 32'd1);
        for (int f = 0; f < 6; f++) sweep(4'b0111, 4'b0000);
        fire();
        check("refill_slot3", 32'(bus.launch_slot), 32'd3);
        check("full_mask", 32'(bus.slot_active), 32'hF);
        for (int f = 0; f < 6; f++) sweep(4'b1111, 4'b0000);
        fire();
        check("full_reject_lv", 32'(bus.launch_valid), 32'd0);
        check("full_reject_mask", 32'(bus.slot_active), 32'hF);
        step();
        // Cooldown was left at 0: a slot freed by a hit is refilled at once
        sweep(4'b1111, 4'b1000);
        check("freed_slot3", 32'(bus.slot_active), 32'h7);
        fire();
        check("cooldown_kept_lv", 32'(bus.launch_valid), 32'd1);
        check("cooldown_kept_slot", 32'(bus.launch_slot), 32'd3);
        step();

        // A frame_tick during a sweep sets sticky overrun and starts nothing
        frame();
        check("ovr_upd_start", 32'(bus.upd_start), 32'd1);
        step();
        frame();
        check("ovr_set", 32'(bus.overrun), 32'd1);
        check("ovr_still_waiting", 32'(bus.upd_slot), 32'd0);
        check("ovr_no_restart", 32'(bus.upd_start), 32'd0);
        bus.upd_done = 1'b1;
        step();
        bus.upd_done = 1'b0;
        serve(1, 1'b0, 1'b0, 0);
        serve(2, 1'b0, 1'b0, 0);
        serve(3, 1'b0, 1'b0, 0);
        step();
        check("ovr_sweep_end", 32'(bus.busy), 32'd0);
        step(3);
        check("ovr_no_second_sweep", 32'(bus.busy), 32'd0);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Leaving gameplay mid-sweep clears everything; a stale hit is ignored
        frame();
        step();
        check("exit_in_wait", 32'(bus.busy), 32'd1);
        bus.game_active = 2'd2;
        step();
        check("exit_mask", 32'(bus.slot_active), 32'd0);
        check("exit_busy", 32'(bus.busy), 32'd0);
        bus.upd_done = 1'b1;
        bus.upd_hit  = 1'b1;
        step();
        bus.upd_done = 1'b0;
        bus.upd_hit  = 1'b0;
        check("exit_stale_hit", 32'(bus.attack_hit), 32'd0);
        fire();
        check("exit_no_launch", 32'(bus.launch_valid), 32'd0);
        frame();
        check("exit_no_sweep", 32'(bus.upd_start), 32'd0);
        check("exit_overrun_kept", 32'(bus.overrun), 32'd1);
        reset_dut();
        check("rst_clears_overrun", 32'(bus.overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
